// File: rtl/ex_m_pipe_stage.sv
// rtl/ex_m_pipe_stage.sv - EX->M pipeline register with valid/ready handshake, optional skid entry and flush
module ex_m_pipe_stage #(
  parameter int DATA_W = 171,
  parameter int CTRL_W = 7,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              stall_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready;
  assign emit   = valid_q & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_t;

      state_t            state;
      logic              ready_q;
      logic [DATA_W-1:0] skid_data;
      logic [CTRL_W-1:0] skid_ctrl;

      // Ready is registered: it drops only once the skid entry is occupied.
      assign in_ready = ready_q;

      // Main/skid occupancy FSM; flush kills everything held and incoming.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state     <= ST_EMPTY;
          valid_q   <= 1'b0;
          ready_q   <= 1'b1;
          data_q    <= '0;
          ctrl_q    <= '0;
          skid_data <= '0;
          skid_ctrl <= '0;
        end else if (flush) begin
          state   <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end else begin
          case (state)
            ST_EMPTY: begin
              if (accept) begin
                data_q  <= in_data;
                ctrl_q  <= in_ctrl;
                valid_q <= 1'b1;
                state   <= ST_FULL;
              end
            end
            ST_FULL: begin
              if (accept && emit) begin
                data_q <= in_data;
                ctrl_q <= in_ctrl;
              end else if (accept) begin
                skid_data <= in_data;
                skid_ctrl <= in_ctrl;
                ready_q   <= 1'b0;
                state     <= ST_SKID;
              end else if (emit) begin
                valid_q <= 1'b0;
                state   <= ST_EMPTY;
              end
            end
            ST_SKID: begin
              if (emit) begin
                data_q  <= skid_data;
                ctrl_q  <= skid_ctrl;
                ready_q <= 1'b1;
                state   <= ST_FULL;
              end
            end
            default: begin
              state   <= ST_EMPTY;
              valid_q <= 1'b0;
              ready_q <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      // Single entry: accept whenever the held beat leaves (or there is none).
      assign in_ready = out_ready | ~valid_q;

      // Single-entry register; flush discards the incoming beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ctrl_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          data_q  <= in_data;
          ctrl_q  <= in_ctrl;
          valid_q <= 1'b1;
        end else if (emit) begin
          valid_q <= 1'b0;
        end
      end
    end
  endgenerate

  // Saturating back-pressure counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (stall_clr) begin
      cnt_q <= '0;
    end else if (valid_q && !out_ready && (cnt_q != '1)) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = valid_q ? ctrl_q : '0;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_ex_m_pipe_stage.sv
// tb/tb_ex_m_pipe_stage.sv - directed bench for ex_m_pipe_stage, SKID=0 and SKID=1 variants
module tb_ex_m_pipe_stage;

  localparam int DW = 171;
  localparam int CW = 7;
  localparam int NW = 4;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          stall_clr;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [DW-1:0] in_data   [2];
  logic [CW-1:0] in_ctrl   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [NW-1:0] stall_cnt [2];
  int            emits     [2];

  int n_checks;
  int n_errors;

  ex_m_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(NW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_ctrl(in_ctrl[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_ctrl(out_ctrl[0]),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt[0])
  );

  ex_m_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(NW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_ctrl(in_ctrl[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_ctrl(out_ctrl[1]),
    .stall_clr(stall_clr), .stall_cnt(stall_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count completed M-side handshakes per instance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      emits[0] <= 0;
      emits[1] <= 0;
    end else begin
      if (out_valid[0] && out_ready[0]) emits[0] <= emits[0] + 1;
      if (out_valid[1] && out_ready[1]) emits[1] <= emits[1] + 1;
    end
  end

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] bd(input int k);
    logic [31:0] w;
    w = 32'h1111_1111 * 32'(k);
    return {11'(k), {5{w}}};
  endfunction

  function automatic logic [CW-1:0] bc(input int k);
    return 7'(k * 9 + 3);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input int k);
    in_valid[d] = 1'b1;
    in_data[d]  = bd(k);
    in_ctrl[d]  = bc(k);
  endtask

  // Asynchronous reset asserted and released between clock edges.
  task automatic reset_all();
    rst_n     = 1'b0;
    flush     = 1'b0;
    stall_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = '0;
      in_ctrl[i]   = '0;
      out_ready[i] = 1'b0;
    end
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run(input int d);
    int e0;
    // Reset state and single-beat latency
    reset_all();
    check($sformatf("d%0d rst out_valid", d), out_valid[d], 1'b0);
    check($sformatf("d%0d rst out_data", d), out_data[d], '0);
    check($sformatf("d%0d rst out_ctrl", d), out_ctrl[d], '0);
    check($sformatf("d%0d rst stall_cnt", d), stall_cnt[d], '0);
    check($sformatf("d%0d rst in_ready", d), in_ready[d], 1'b1);
    out_ready[d] = 1'b1;
    in_valid[d]  = 1'b1;
    in_data[d]   = bd(1);
    in_ctrl[d]   = 7'h7F;
    step();
    check($sformatf("d%0d t1 out_valid", d), out_valid[d], 1'b1);
    check($sformatf("d%0d t1 out_ctrl", d), out_ctrl[d], 7'h7F);
    check($sformatf("d%0d t1 out_data", d), out_data[d], bd(1));
    check($sformatf("d%0d t1 stall_cnt", d), stall_cnt[d], '0);
    in_valid[d] = 1'b0;
    step();
    check($sformatf("d%0d t1 bubble valid", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t1 bubble ctrl", d), out_ctrl[d], '0);

    // Back-pressure with three beats A=2, B=3, C=4
    reset_all();
    drive(d, 2);
    step();
    check($sformatf("d%0d t2 A data", d), out_data[d], bd(2));
    check($sformatf("d%0d t2 A rdy", d), in_ready[d], (d == 1));
    drive(d, 3);
    step();
    check($sformatf("d%0d t2 B rdy", d), in_ready[d], 1'b0);
    check($sformatf("d%0d t2 hold A", d), out_data[d], bd(2));
    check($sformatf("d%0d t2 stall1", d), stall_cnt[d], 4'd1);
    if (d == 1) drive(d, 4);
    step();
    step();
    check($sformatf("d%0d t2 stall3", d), stall_cnt[d], 4'd3);
    check($sformatf("d%0d t2 hold A ctrl", d), out_ctrl[d], bc(2));
    out_ready[d] = 1'b1;
    #1;
    check($sformatf("d%0d t2 rdy release", d), in_ready[d], (d == 0));
    step();
    check($sformatf("d%0d t2 out B", d), out_data[d], bd(3));
    check($sformatf("d%0d t2 stall kept", d), stall_cnt[d], 4'd3);
    check($sformatf("d%0d t2 rdy after", d), in_ready[d], 1'b1);
    drive(d, 4);
    step();
    check($sformatf("d%0d t2 out C", d), out_data[d], bd(4));
    check($sformatf("d%0d t2 out C ctrl", d), out_ctrl[d], bc(4));
    in_valid[d] = 1'b0;
    step();
    check($sformatf("d%0d t2 drained", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t2 emits", d), emits[d], 3);

    // Flush while stalled with an incoming beat D=5
    reset_all();
    drive(d, 2);
    step();
    if (d == 1) begin
      drive(d, 3);
      step();
    end
    drive(d, 5);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid[d] = 1'b0;
    check($sformatf("d%0d t3 valid", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t3 ctrl", d), out_ctrl[d], '0);
    check($sformatf("d%0d t3 rdy", d), in_ready[d], 1'b1);
    out_ready[d] = 1'b1;
    step();
    check($sformatf("d%0d t3 no D", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t3 emits", d), emits[d], 0);
    // Flush on an empty stage drops the incoming beat
    drive(d, 6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid[d] = 1'b0;
    check($sformatf("d%0d t3 empty flush", d), out_valid[d], 1'b0);

    // Flush together with emit
    reset_all();
    out_ready[d] = 1'b1;
    drive(d, 7);
    step();
    in_valid[d] = 1'b0;
    flush = 1'b1;
    e0 = emits[d];
    check($sformatf("d%0d t4 pre valid", d), out_valid[d], 1'b1);
    step();
    flush = 1'b0;
    check($sformatf("d%0d t4 post valid", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t4 one emit", d), emits[d] - e0, 1);
    step();
    check($sformatf("d%0d t4 no dup", d), emits[d] - e0, 1);

    // Counter saturation and clear priority
    reset_all();
    drive(d, 8);
    step();
    in_valid[d] = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check($sformatf("d%0d t5 sat", d), stall_cnt[d], 4'd15);
    stall_clr = 1'b1;
    step();
    check($sformatf("d%0d t5 clr", d), stall_cnt[d], 4'd0);
    stall_clr = 1'b0;
    step();
    check($sformatf("d%0d t5 resume", d), stall_cnt[d], 4'd1);

    // Asynchronous reset mid-stream
    reset_all();
    drive(d, 9);
    step();
    drive(d, 10);
    step();
    rst_n = 1'b0;
    #2;
    check($sformatf("d%0d t6 valid", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t6 ctrl", d), out_ctrl[d], '0);
    check($sformatf("d%0d t6 data", d), out_data[d], '0);
    check($sformatf("d%0d t6 stall", d), stall_cnt[d], '0);
    check($sformatf("d%0d t6 rdy", d), in_ready[d], 1'b1);
    in_valid[d]  = 1'b0;
    out_ready[d] = 1'b1;
    rst_n = 1'b1;
    step();
    check($sformatf("d%0d t6 no stale", d), out_valid[d], 1'b0);
    check($sformatf("d%0d t6 bubble ctrl", d), out_ctrl[d], '0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_all();
    step();
    run(1);
    run(0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
